// File: rtl/div_seq_fx_pkg.sv
// Shared types and helpers for the div_seq_fx sequential divider.
// The optional saturating result mode is selected by defining DIV_SAT_EN.
package div_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Wide container used to hand back width-dependent constants.
   localparam int SAT_W = 128;

   // Counter width able to hold the iteration count W+FRAC.
   function automatic int iter_cnt_w(input int w, input int frac);
      return $clog2(w + frac + 1);
   endfunction

   // Largest positive two's complement value of width w (2^(w-1)-1).
   function automatic logic [SAT_W-1:0] sat_pos(input int w);
      return ({{(SAT_W-1){1'b0}}, 1'b1} << (w - 1)) - {{(SAT_W-1){1'b0}}, 1'b1};
   endfunction

   // Most negative two's complement value of width w (-2^(w-1)).
   function automatic logic [SAT_W-1:0] sat_neg(input int w);
      return {{(SAT_W-1){1'b0}}, 1'b1} << (w - 1);
   endfunction

endpackage

// File: rtl/div_seq_fx_if.sv
// Operand/result handshake bundle for div_seq_fx.
// master = producer/consumer side, slave = divider side.
interface div_seq_fx_if #(
   parameter int W = 48
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_zero;
   logic         overflow;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_zero, overflow
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_zero, overflow
   );
endinterface

// File: rtl/div_seq_step.sv
// One radix-2 restoring step: shift in the next dividend bit, trial-subtract
// the divisor magnitude, keep the shifted value if the trial went negative.
module div_seq_step #(
   parameter int W = 48
) (
   input  logic [W-1:0] rem_i,
   input  logic         bit_i,
   input  logic [W-1:0] den_i,
   output logic [W-1:0] rem_o,
   output logic         q_o
);
   logic [W:0]   rem_sh_s;
   logic [W+1:0] trial_s;
   logic         unused_trial_s;

   // Trial subtraction and restore decision; remainder always fits W bits
   // because it stays below the divisor magnitude.
   always_comb begin
      rem_sh_s = {rem_i, bit_i};
      trial_s  = {1'b0, rem_sh_s} - {2'b00, den_i};
      if (trial_s[W+1]) begin
         rem_o = rem_sh_s[W-1:0];
         q_o   = 1'b0;
      end else begin
         rem_o = trial_s[W-1:0];
         q_o   = 1'b1;
      end
   end

   assign unused_trial_s = trial_s[W];
endmodule

// File: rtl/div_seq_fx.sv
// Sequential signed fixed-point divider, one quotient bit per clock.
// q = trunc((dividend * 2^FRAC) / divisor), remainder carries dividend's sign.
// Define DIV_SAT_EN to saturate on overflow / divide-by-zero instead of wrapping.
module div_seq_fx
   import div_seq_pkg::*;
#(
   parameter int W    = 48,
   parameter int FRAC = 0
) (
   input logic          clk,
   input logic          rst,
   div_seq_fx_if.slave  bus
);
   localparam int M  = W + FRAC;
   localparam int CW = iter_cnt_w(W, FRAC);

   localparam logic [CW-1:0] N_CNT   = CW'(M);
   localparam logic [CW-1:0] ONE_CNT = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
   localparam logic [W-1:0]  ZERO_W  = {W{1'b0}};
   localparam logic [W-1:0]  ONE_W   = {{(W-1){1'b0}}, 1'b1};
   localparam logic [M-1:0]  ONE_M   = {{(M-1){1'b0}}, 1'b1};
   localparam logic [M-1:0]  NEG_LIM = ONE_M << (W - 1);
   localparam logic [M-1:0]  POS_LIM = NEG_LIM - ONE_M;
`ifdef DIV_SAT_EN
   localparam logic [SAT_W-1:0] SAT_POS_WIDE = sat_pos(W);
   localparam logic [SAT_W-1:0] SAT_NEG_WIDE = sat_neg(W);
   localparam logic [W-1:0]     SAT_POS = SAT_POS_WIDE[W-1:0];
   localparam logic [W-1:0]     SAT_NEG = SAT_NEG_WIDE[W-1:0];
`endif

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [M-1:0]  num_q, num_d;
   logic [W-1:0]  den_q, den_d;
   logic [W-1:0]  rem_q, rem_d;
   logic          sign_n_q, sign_n_d;
   logic          sign_d_q, sign_d_d;
   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  quot_q, quot_d;
   logic [W-1:0]  rem_out_q, rem_out_d;
   logic          div_zero_q, div_zero_d;
   logic          overflow_q, overflow_d;

   logic [W-1:0]  abs_n_s, abs_d_s;
   logic [W-1:0]  step_rem_s;
   logic          step_q_s;
   logic [M-1:0]  q_mag_s, q_wide_s;
   logic [W-1:0]  q_low_s, r_fin_s;
   logic          neg_s, ov_s;

   div_seq_step #(.W(W)) u_step (
      .rem_i (rem_q),
      .bit_i (num_q[M-1]),
      .den_i (den_q),
      .rem_o (step_rem_s),
      .q_o   (step_q_s)
   );

   // Operand magnitudes; |-2^(W-1)| is representable as unsigned W bits.
   assign abs_n_s = bus.dividend[W-1] ? (~bus.dividend + ONE_W) : bus.dividend;
   assign abs_d_s = bus.divisor[W-1]  ? (~bus.divisor  + ONE_W) : bus.divisor;

   // Result of the final iteration, sign-corrected and range-checked.
   assign q_mag_s  = {num_q[M-2:0], step_q_s};
   assign neg_s    = sign_n_q ^ sign_d_q;
   assign q_wide_s = neg_s ? (~q_mag_s + ONE_M) : q_mag_s;
   assign q_low_s  = q_wide_s[W-1:0];
   assign ov_s     = neg_s ? (q_mag_s > NEG_LIM) : (q_mag_s > POS_LIM);
   assign r_fin_s  = sign_n_q ? (~step_rem_s + ONE_W) : step_rem_s;

   // Next-state, datapath and output-register computation for the FSM.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      num_d       = num_q;
      den_d       = den_q;
      rem_d       = rem_q;
      sign_n_d    = sign_n_q;
      sign_d_d    = sign_d_q;
      out_valid_d = out_valid_q;
      quot_d      = quot_q;
      rem_out_d   = rem_out_q;
      div_zero_d  = div_zero_q;
      overflow_d  = overflow_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               sign_n_d = bus.dividend[W-1];
               sign_d_d = bus.divisor[W-1];
               num_d    = M'(abs_n_s) << FRAC;
               den_d    = abs_d_s;
               rem_d    = ZERO_W;
               cnt_d    = N_CNT;
               if (bus.divisor == ZERO_W) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  div_zero_d  = 1'b1;
                  overflow_d  = 1'b0;
`ifdef DIV_SAT_EN
                  quot_d    = bus.dividend[W-1] ? SAT_NEG : SAT_POS;
                  rem_out_d = ZERO_W;
`else
                  quot_d    = ZERO_W;
                  rem_out_d = bus.dividend;
`endif
               end else begin
                  state_d = CALC;
               end
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            num_d = q_mag_s;
            rem_d = step_rem_s;
            cnt_d = cnt_q - ONE_CNT;
            if (cnt_q == ONE_CNT) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               div_zero_d  = 1'b0;
               overflow_d  = ov_s;
               rem_out_d   = r_fin_s;
`ifdef DIV_SAT_EN
               quot_d = ov_s ? (neg_s ? SAT_NEG : SAT_POS) : q_low_s;
`else
               quot_d = q_low_s;
`endif
            end else begin
               state_d = CALC;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= ZERO_CNT;
         num_q       <= {M{1'b0}};
         den_q       <= ZERO_W;
         rem_q       <= ZERO_W;
         sign_n_q    <= 1'b0;
         sign_d_q    <= 1'b0;
         out_valid_q <= 1'b0;
         quot_q      <= ZERO_W;
         rem_out_q   <= ZERO_W;
         div_zero_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         num_q       <= num_d;
         den_q       <= den_d;
         rem_q       <= rem_d;
         sign_n_q    <= sign_n_d;
         sign_d_q    <= sign_d_d;
         out_valid_q <= out_valid_d;
         quot_q      <= quot_d;
         rem_out_q   <= rem_out_d;
         div_zero_q  <= div_zero_d;
         overflow_q  <= overflow_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.quotient  = quot_q;
   assign bus.remainder = rem_out_q;
   assign bus.div_zero  = div_zero_q;
   assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_div_seq_fx.sv
// Directed bench for div_seq_fx: integer instance (FRAC=0) and Q24 instance.
// Expected values follow DIV_SAT_EN when the bundle is built with it.
module tb_div_seq_fx;
   logic clk;
   logic rst;
   int   n_pass;
   int   n_fail;
   int   n_total;
   int   lat;

   div_seq_fx_if #(.W(48)) a_if ();
   div_seq_fx_if #(.W(48)) b_if ();

   div_seq_fx #(.W(48), .FRAC(0))  u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
   div_seq_fx #(.W(48), .FRAC(24)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present operands on A and pass the accepting edge.
   task automatic start_a(input logic [47:0] a, input logic [47:0] b);
      @(negedge clk);
      check("a_in_ready_before_accept", {47'd0, a_if.in_ready}, 48'd1);
      a_if.in_valid = 1'b1;
      a_if.dividend = a;
      a_if.divisor  = b;
      @(posedge clk);
      #1;
      a_if.in_valid = 1'b0;
   endtask

   // Edges to out_valid, counting the accepting edge as the first.
   task automatic wait_a(output int l);
      l = 1;
      while (!a_if.out_valid && l < 200) begin
         @(posedge clk);
         #1;
         l++;
      end
   endtask

   task automatic wait_b(output int l);
      l = 1;
      while (!b_if.out_valid && l < 200) begin
         @(posedge clk);
         #1;
         l++;
      end
   endtask

   task automatic op_a(input string tag, input logic [47:0] a, input logic [47:0] b,
                       input logic [47:0] eq, input logic [47:0] er, input int elat,
                       input logic edz, input logic eov);
      int l;
      start_a(a, b);
      wait_a(l);
      check({tag, "_lat"}, 48'(l), 48'(elat));
      check({tag, "_q"}, a_if.quotient, eq);
      check({tag, "_r"}, a_if.remainder, er);
      check({tag, "_dz"}, {47'd0, a_if.div_zero}, {47'd0, edz});
      check({tag, "_ov"}, {47'd0, a_if.overflow}, {47'd0, eov});
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_pass = 0; n_fail = 0; n_total = 0;
      rst = 1'b1;
      a_if.in_valid = 1'b0; a_if.dividend = 48'd0; a_if.divisor = 48'd0; a_if.out_ready = 1'b1;
      b_if.in_valid = 1'b0; b_if.dividend = 48'd0; b_if.divisor = 48'd0; b_if.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {47'd0, a_if.out_valid}, 48'd0);
      check("rst_quotient", a_if.quotient, 48'd0);
      check("rst_remainder", a_if.remainder, 48'd0);
      check("rst_flags", {46'd0, a_if.div_zero, a_if.overflow}, 48'd0);
      check("rst_in_ready", {47'd0, a_if.in_ready}, 48'd1);
      @(negedge clk);
      rst = 1'b0;

      // Sign combinations, integer mode.
      op_a("p7_p2", 48'd7, 48'd2, 48'd3, 48'd1, 49, 1'b0, 1'b0);
      op_a("m7_p2", 48'hFFFF_FFFF_FFF9, 48'd2, 48'hFFFF_FFFF_FFFD, 48'hFFFF_FFFF_FFFF, 49, 1'b0, 1'b0);
      op_a("p7_m2", 48'd7, 48'hFFFF_FFFF_FFFE, 48'hFFFF_FFFF_FFFD, 48'd1, 49, 1'b0, 1'b0);
      op_a("m7_m2", 48'hFFFF_FFFF_FFF9, 48'hFFFF_FFFF_FFFE, 48'd3, 48'hFFFF_FFFF_FFFF, 49, 1'b0, 1'b0);

      // Divide by zero and the single overflowing integer case.
`ifdef DIV_SAT_EN
      op_a("div0", 48'hFFFF_FFFF_FFFB, 48'd0, 48'h8000_0000_0000, 48'd0, 1, 1'b1, 1'b0);
      op_a("ovf", 48'h8000_0000_0000, 48'hFFFF_FFFF_FFFF, 48'h7FFF_FFFF_FFFF, 48'd0, 49, 1'b0, 1'b1);
`else
      op_a("div0", 48'hFFFF_FFFF_FFFB, 48'd0, 48'd0, 48'hFFFF_FFFF_FFFB, 1, 1'b1, 1'b0);
      op_a("ovf", 48'h8000_0000_0000, 48'hFFFF_FFFF_FFFF, 48'h8000_0000_0000, 48'd0, 49, 1'b0, 1'b1);
`endif
      op_a("min_p1", 48'h8000_0000_0000, 48'd1, 48'h8000_0000_0000, 48'd0, 49, 1'b0, 1'b0);

      // Q24: 1.0 / 3.0.
      @(negedge clk);
      check("b_in_ready", {47'd0, b_if.in_ready}, 48'd1);
      b_if.in_valid = 1'b1;
      b_if.dividend = 48'h00_0000_1000000;
      b_if.divisor  = 48'h00_0000_3000000;
      @(posedge clk);
      #1;
      b_if.in_valid = 1'b0;
      wait_b(lat);
      check("q24_lat", 48'(lat), 48'd73);
      check("q24_q", b_if.quotient, 48'h55_5555);
      check("q24_r", b_if.remainder, 48'h100_0000);
      check("q24_flags", {46'd0, b_if.div_zero, b_if.overflow}, 48'd0);
      @(posedge clk);
      #1;

      // Back-pressure: result held for 10 clocks, then back-to-back op.
      a_if.out_ready = 1'b0;
      start_a(48'd20, 48'd3);
      wait_a(lat);
      check("bp_lat", 48'(lat), 48'd49);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("bp_valid", {47'd0, a_if.out_valid}, 48'd1);
         check("bp_in_ready", {47'd0, a_if.in_ready}, 48'd0);
         check("bp_q", a_if.quotient, 48'd6);
         check("bp_r", a_if.remainder, 48'd2);
      end
      @(negedge clk);
      a_if.out_ready = 1'b1;
      a_if.in_valid  = 1'b1;
      a_if.dividend  = 48'd9;
      a_if.divisor   = 48'd4;
      @(posedge clk);
      #1;
      check("rel_idle", {46'd0, a_if.in_ready, a_if.out_valid}, 48'd2);
      @(posedge clk);
      #1;
      a_if.in_valid = 1'b0;
      check("rel_accepted", {47'd0, a_if.in_ready}, 48'd0);
      wait_a(lat);
      check("rel_lat", 48'(lat), 48'd49);
      check("rel_q", a_if.quotient, 48'd2);
      check("rel_r", a_if.remainder, 48'd1);
      @(posedge clk);
      #1;

      // Reset during iteration 20 abandons the division.
      start_a(48'd1000, 48'd3);
      repeat (19) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_in_ready", {47'd0, a_if.in_ready}, 48'd1);
      check("mid_rst_valid", {47'd0, a_if.out_valid}, 48'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      check("mid_rst_no_result", {47'd0, a_if.out_valid}, 48'd0);
      op_a("after_rst", 48'd100, 48'd7, 48'd14, 48'd2, 49, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
